// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory responder for a CPU data port.
// Define DMEM_RESPONDER_ERR_EN to flag misaligned accesses on err_o and suppress their effect.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0] CntInit = 4'(LATENCY - 2);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic          write_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          ack_q;
   logic          busy_q;
   logic          err_q;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] idx;
   logic          access;
   logic          misaligned;
   logic [31:0]   rd_word;
   logic          unused_addr;

   assign idx    = addr_q[AW+1:2];
   assign access = (state_q == StWait) && (cnt_q == 4'd0);

`ifdef DMEM_RESPONDER_ERR_EN
   assign misaligned  = |addr_q[1:0];
   assign unused_addr = ^addr_i[31:AW+2];
`else
   assign misaligned  = 1'b0;
   assign unused_addr = ^{addr_i[31:AW+2], addr_q[1:0]};
`endif

   assign rd_word = misaligned ? 32'h0 : mem_q[idx];

   // Array has no reset; state_q is forced to StIdle during reset, so no write can slip through.
   always_ff @(posedge clk_i) begin
      if (access && write_q && !misaligned) begin
         mem_q[idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_i) begin
                  write_q <= write_i;
                  addr_q  <= addr_i[AW+1:0];
                  wdata_q <= wdata_i;
                  cnt_q   <= CntInit;
                  state_q <= StWait;
                  busy_q  <= 1'b1;
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q <= StAck;
                  ack_q   <= 1'b1;
                  err_q   <= misaligned;
                  rdata_q <= write_q ? 32'h0 : rd_word;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StAck: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata_o = rdata_q;
   assign ack_o   = ack_q;
   assign busy_o  = busy_q;
   assign err_o   = err_q;

endmodule
